// File: rtl/debounce2_if.sv
// debounce2_if: button/level bundle between board switches and the debouncer (btn in; db, rise, fall, tog out)
interface debounce2_if;
  logic [1:0] btn;
  logic [1:0] db;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] tog;
  modport master(output btn, input db, rise, fall, tog);
  modport slave(input btn, output db, rise, fall, tog);
endinterface

// File: rtl/debounce2.sv
// debounce2: two-channel button debouncer (clk, rst, bus.btn -> bus.db/rise/fall/tog); DEBOUNCE2_TOGGLE_EN builds tog registers
module debounce2 #(
  parameter int DB_CYCLES = 120000,
  parameter int CNT_W = 17
) (
  input logic clk,
  input logic rst,
  debounce2_if.slave bus
);
  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
  logic [1:0] s1, s2, db, rise, fall, tog;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.btn;
      s2 <= s1;
    end
  end
  for (genvar i = 0; i < 2; i++) begin : g_ch
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic db_q, rise_q, fall_q, rise_n, fall_n;
    always_comb begin
      state_n = state;
      cnt_n = '0;
      rise_n = 1'b0;
      fall_n = 1'b0;
      case (state)
        IDLE_LO: if (s2[i]) begin
          state_n = (LAST == '0) ? IDLE_HI : WAIT_HI;
          rise_n = (LAST == '0);
          cnt_n = (LAST == '0) ? '0 : CNT_W'(1);
        end
        WAIT_HI: if (!s2[i]) state_n = IDLE_LO;
          else if (cnt == LAST) begin
            state_n = IDLE_HI;
            rise_n = 1'b1;
          end else cnt_n = cnt + 1'b1;
        IDLE_HI: if (!s2[i]) begin
          state_n = (LAST == '0) ? IDLE_LO : WAIT_LO;
          fall_n = (LAST == '0);
          cnt_n = (LAST == '0) ? '0 : CNT_W'(1);
        end
        WAIT_LO: if (s2[i]) state_n = IDLE_HI;
          else if (cnt == LAST) begin
            state_n = IDLE_LO;
            fall_n = 1'b1;
          end else cnt_n = cnt + 1'b1;
        default: state_n = IDLE_LO;
      endcase
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        state <= IDLE_LO;
        cnt <= '0;
        db_q <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        state <= state_n;
        cnt <= cnt_n;
        db_q <= (state_n == IDLE_HI) || (state_n == WAIT_LO);
        rise_q <= rise_n;
        fall_q <= fall_n;
      end
    end
    assign db[i] = db_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
`ifdef DEBOUNCE2_TOGGLE_EN
    logic tog_q;
    always_ff @(posedge clk) tog_q <= rst ? 1'b0 : tog_q ^ rise_n;
    assign tog[i] = tog_q;
`else
    assign tog[i] = 1'b0;
`endif
  end
  assign bus.db = db;
  assign bus.rise = rise;
  assign bus.fall = fall;
  assign bus.tog = tog;
endmodule
